// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU/branch/jal path plus an iterative
// multiply (shift-add) and unsigned restoring divide sharing one counter.
//
// state | meaning
// IDLE  | accepting; single-cycle ops complete the following cycle
// MUL   | shift-add multiply in progress, one multiplier bit per cycle
// DIV   | restoring divide in progress, one quotient bit per cycle
module ex_stage_mc #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] oper1,
  input  logic [XLEN-1:0] oper2,
  input  logic [OPW-1:0]  alu_op,
  input  logic            is_beq,
  input  logic            is_bne,
  input  logic            is_blt,
  input  logic            is_bge,
  input  logic            is_jal,
  input  logic            is_mul,
  input  logic            is_div,
  input  logic            is_rem,
  input  logic            predicted,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_out,
  output logic            wrong_prediction
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t          state;
  logic [SHW-1:0]  count;
  // mc_a: multiplicand (shifted left) or divisor
  // mc_b: multiplier (shifted right) or dividend/quotient
  // mc_acc: product accumulator or partial remainder
  logic [XLEN-1:0] mc_a;
  logic [XLEN-1:0] mc_b;
  logic [XLEN-1:0] mc_acc;
  logic            want_rem;

  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] single_res;
  logic            is_branch;
  logic            taken;
  logic            lt_signed;
  logic [SHW-1:0]  shamt;

  logic [XLEN-1:0] mul_acc_nxt;
  logic [XLEN:0]   rem_sh;
  logic            div_ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  assign in_ready = (state == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // Single-cycle result and branch resolution
  always_comb begin
    shamt     = oper2[SHW-1:0];
    lt_signed = $signed(oper1) < $signed(oper2);
    alu_res   = oper1 + oper2;
    case (alu_op)
      OPW'(1): alu_res = oper1 - oper2;
      OPW'(2): alu_res = oper1 & oper2;
      OPW'(3): alu_res = oper1 | oper2;
      OPW'(4): alu_res = oper1 ^ oper2;
      OPW'(5): alu_res = oper1 << shamt;
      OPW'(6): alu_res = oper1 >> shamt;
      OPW'(7): alu_res = $signed(oper1) >>> shamt;
      OPW'(8): alu_res = {{(XLEN-1){1'b0}}, lt_signed};
      OPW'(9): alu_res = {{(XLEN-1){1'b0}}, oper1 < oper2};
      default: alu_res = oper1 + oper2;
    endcase
    is_branch = is_beq | is_bne | is_blt | is_bge;
    taken     = (is_beq & (oper1 == oper2)) | (is_bne & (oper1 != oper2)) |
                (is_blt & lt_signed) | (is_bge & !lt_signed) | is_jal;
    if (is_jal)         single_res = pc + XLEN'(1);
    else if (is_branch) single_res = oper1 - oper2;
    else                single_res = alu_res;
  end

  // One multiply / divide iteration
  always_comb begin
    mul_acc_nxt = mc_acc + (mc_b[0] ? mc_a : '0);
    rem_sh      = {mc_acc, mc_b[XLEN-1]};
    div_ge      = rem_sh >= {1'b0, mc_a};
    rem_nxt     = div_ge ? rem_sh[XLEN-1:0] - mc_a : rem_sh[XLEN-1:0];
    quo_nxt     = {mc_b[XLEN-2:0], div_ge};
  end

  // Stage FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      mc_a             <= '0;
      mc_b             <= '0;
      mc_acc           <= '0;
      want_rem         <= 1'b0;
      out_valid        <= 1'b0;
      alu_out          <= '0;
      wrong_prediction <= 1'b0;
    end else if (flush) begin
      state            <= IDLE;
      count            <= '0;
      out_valid        <= 1'b0;
      wrong_prediction <= 1'b0;
    end else begin
      out_valid        <= 1'b0;
      wrong_prediction <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state  <= MUL;
              count  <= SHW'(XLEN-1);
              mc_a   <= oper1;
              mc_b   <= oper2;
              mc_acc <= '0;
            end else if (is_div || is_rem) begin
              state    <= DIV;
              count    <= SHW'(XLEN-1);
              mc_a     <= oper2;
              mc_b     <= oper1;
              mc_acc   <= '0;
              want_rem <= is_rem;
            end else begin
              out_valid        <= 1'b1;
              alu_out          <= single_res;
              wrong_prediction <= (is_branch | is_jal) & (taken ^ predicted);
            end
          end
        end
        MUL: begin
          mc_acc <= mul_acc_nxt;
          mc_a   <= mc_a << 1;
          mc_b   <= mc_b >> 1;
          if (count == '0) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            alu_out   <= mul_acc_nxt;
          end else begin
            count <= count - SHW'(1);
          end
        end
        DIV: begin
          mc_acc <= rem_nxt;
          mc_b   <= quo_nxt;
          if (count == '0) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            alu_out   <= want_rem ? rem_nxt : quo_nxt;
          end else begin
            count <= count - SHW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for ex_stage_mc: vector table, randomized traffic against a
// reference model, and hand-written multi-cycle / flush / reset sequences.
module tb_ex_stage_mc;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   pc, oper1, oper2;
  logic [3:0]        alu_op;
  logic [4:0]        br;  // {beq, bne, blt, bge, jal}
  logic              is_mul, is_div, is_rem;
  logic              predicted;
  logic              flush;
  logic              out_valid;
  logic [XLEN-1:0]   alu_out;
  logic              wrong_prediction;

  int tests  = 0;
  int failed = 0;

  ex_stage_mc #(.XLEN(XLEN), .OPW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .oper1(oper1), .oper2(oper2), .alu_op(alu_op),
    .is_beq(br[4]), .is_bne(br[3]), .is_blt(br[2]), .is_bge(br[1]), .is_jal(br[0]),
    .is_mul(is_mul), .is_div(is_div), .is_rem(is_rem),
    .predicted(predicted), .flush(flush),
    .out_valid(out_valid), .alu_out(alu_out), .wrong_prediction(wrong_prediction)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_single(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [XLEN-1:0] p, input logic [4:0] cls, input logic pr);
    in_valid = 1'b1; alu_op = op; oper1 = a; oper2 = b; pc = p; br = cls; predicted = pr;
    is_mul = 1'b0; is_div = 1'b0; is_rem = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; br = '0; is_mul = 1'b0; is_div = 1'b0; is_rem = 1'b0; predicted = 1'b0;
  endtask

  // Reference: result and misprediction of a single-cycle instruction
  function automatic logic [XLEN:0] ref_single(input logic [3:0] op, input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b, input logic [XLEN-1:0] p, input logic [4:0] cls, input logic pr);
    logic [XLEN-1:0] r;
    logic t;
    int sa, sb, sh;
    sa = a; sb = b; sh = b % XLEN;
    t = 1'b0;
    case (cls)
      5'b10000: begin r = a - b; t = (a == b); end
      5'b01000: begin r = a - b; t = (a != b); end
      5'b00100: begin r = a - b; t = (sa < sb); end
      5'b00010: begin r = a - b; t = (sa >= sb); end
      5'b00001: begin r = p + 1; t = 1'b1; end
      default: begin
        case (op)
          4'd1: r = a - b;
          4'd2: r = a & b;
          4'd3: r = a | b;
          4'd4: r = a ^ b;
          4'd5: r = a << sh;
          4'd6: r = a >> sh;
          4'd7: r = sa >>> sh;
          4'd8: r = (sa < sb) ? 1 : 0;
          4'd9: r = (a < b) ? 1 : 0;
          default: r = a + b;
        endcase
      end
    endcase
    return {(cls != 5'b0) ? (t ^ pr) : 1'b0, r};
  endfunction

  // Reference: kind 0 mul, 1 div, 2 rem
  function automatic logic [XLEN-1:0] ref_mc(input int kind, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] prod;
    prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    case (kind)
      0: return prod[XLEN-1:0];
      1: return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Accept a mul/div/rem, scramble inputs while busy, check the XLEN-cycle pulse
  task automatic run_mc(input string name, input int kind, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
    idle_inputs();
    in_valid = 1'b1; oper1 = a; oper2 = b; alu_op = 4'd0;
    is_mul = (kind == 0); is_div = (kind == 1); is_rem = (kind == 2);
    tick();
    for (int k = 1; k < XLEN; k++) begin
      oper1 = $urandom; oper2 = $urandom; in_valid = 1'($urandom);
      tick();
      check({name, "_busy"}, {30'b0, out_valid, in_ready}, 32'd0);
    end
    tick();
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_ready"}, {31'b0, in_ready}, 32'd1);
    check({name, "_result"}, alu_out, exp);
    check({name, "_wp"}, {31'b0, wrong_prediction}, 32'd0);
    idle_inputs();
  endtask

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a, b, p;
    logic [4:0]      cls;
    logic            pr;
    logic [XLEN-1:0] exp_res;
    logic            exp_wp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [XLEN:0] m;
    int pulses;
    vecs[0]  = '{4'd0,  32'd5,          32'd7,          32'd0,    5'b00000, 1'b0, 32'd12,         1'b0};
    vecs[1]  = '{4'd1,  32'd3,          32'd5,          32'd0,    5'b00000, 1'b0, 32'hFFFFFFFE,   1'b0};
    vecs[2]  = '{4'd2,  32'hF0F0,       32'hFF00,       32'd0,    5'b00000, 1'b0, 32'hF000,       1'b0};
    vecs[3]  = '{4'd3,  32'hF0F0,       32'h0F0F,       32'd0,    5'b00000, 1'b0, 32'hFFFF,       1'b0};
    vecs[4]  = '{4'd4,  32'hFF,         32'h0F,         32'd0,    5'b00000, 1'b0, 32'hF0,         1'b0};
    vecs[5]  = '{4'd5,  32'd1,          32'd35,         32'd0,    5'b00000, 1'b0, 32'd8,          1'b0};
    vecs[6]  = '{4'd6,  32'h80000000,   32'd4,          32'd0,    5'b00000, 1'b0, 32'h08000000,   1'b0};
    vecs[7]  = '{4'd7,  32'h80000000,   32'd4,          32'd0,    5'b00000, 1'b0, 32'hF8000000,   1'b0};
    vecs[8]  = '{4'd8,  32'hFFFFFFFF,   32'd1,          32'd0,    5'b00000, 1'b0, 32'd1,          1'b0};
    vecs[9]  = '{4'd9,  32'hFFFFFFFF,   32'd1,          32'd0,    5'b00000, 1'b0, 32'd0,          1'b0};
    vecs[10] = '{4'd15, 32'd2,          32'd3,          32'd0,    5'b00000, 1'b1, 32'd5,          1'b0};
    vecs[11] = '{4'd0,  32'd9,          32'd9,          32'd0,    5'b10000, 1'b0, 32'd0,          1'b1};
    vecs[12] = '{4'd0,  32'hFFFFFFFF,   32'd0,          32'd0,    5'b00010, 1'b0, 32'hFFFFFFFF,   1'b0};
    vecs[13] = '{4'd0,  32'd0,          32'd0,          32'h40,   5'b00001, 1'b1, 32'h41,         1'b0};
    vecs[14] = '{4'd0,  32'd1,          32'd2,          32'd0,    5'b01000, 1'b1, 32'hFFFFFFFF,   1'b0};
    vecs[15] = '{4'd0,  32'd1,          32'd2,          32'd0,    5'b00100, 1'b0, 32'hFFFFFFFF,   1'b1};

    rst = 1'b1; flush = 1'b0; pc = '0; oper1 = '0; oper2 = '0; alu_op = '0;
    idle_inputs();
    #12;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_alu_out", alu_out, 32'd0);
    check("reset_wp", {31'b0, wrong_prediction}, 32'd0);
    rst = 1'b0;
    tick();
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);

    // back-to-back single-cycle vectors
    for (int i = 0; i < 16; i++) begin
      set_single(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].cls, vecs[i].pr);
      tick();
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d_res", i), alu_out, vecs[i].exp_res);
      check($sformatf("vec%0d_wp", i), {31'b0, wrong_prediction}, {31'b0, vecs[i].exp_wp});
    end

    // no accept: pulse drops, result holds
    idle_inputs();
    tick();
    check("hold_valid", {31'b0, out_valid}, 32'd0);
    check("hold_res", alu_out, 32'hFFFFFFFF);
    check("hold_wp", {31'b0, wrong_prediction}, 32'd0);

    // randomized single-cycle traffic
    for (int i = 0; i < 200; i++) begin
      logic [4:0] cls;
      logic [XLEN-1:0] a, b;
      case ($urandom_range(0, 9))
        0: cls = 5'b10000; 1: cls = 5'b01000; 2: cls = 5'b00100;
        3: cls = 5'b00010; 4: cls = 5'b00001; default: cls = 5'b00000;
      endcase
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      set_single(4'($urandom), a, b, $urandom, cls, 1'($urandom));
      m = ref_single(alu_op, oper1, oper2, pc, br, predicted);
      tick();
      check("rnd_valid", {31'b0, out_valid}, 32'd1);
      check("rnd_res", alu_out, m[XLEN-1:0]);
      check("rnd_wp", {31'b0, wrong_prediction}, {31'b0, m[XLEN]});
    end

    // directed multi-cycle cases; add accepted in the completion cycle
    run_mc("mul_6_7", 0, 32'd6, 32'd7, 32'd42);
    set_single(4'd0, 32'd5, 32'd7, 32'd0, 5'b0, 1'b0);
    tick();
    check("add_after_mul_valid", {31'b0, out_valid}, 32'd1);
    check("add_after_mul_res", alu_out, 32'd12);
    idle_inputs();
    run_mc("div_by0", 1, 32'd100, 32'd0, 32'hFFFFFFFF);
    run_mc("rem_by0", 2, 32'd100, 32'd0, 32'd100);
    run_mc("div_max_2", 1, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF);

    // randomized multi-cycle
    for (int i = 0; i < 24; i++) begin
      int kind;
      logic [XLEN-1:0] a, b;
      kind = $urandom_range(0, 2);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0; 1: b = $urandom_range(1, 1000); default: b = $urandom;
      endcase
      run_mc("rnd_mc", kind, a, b, ref_mc(kind, a, b));
    end

    // flush 10 cycles into a divide, with in_valid high during the flush
    idle_inputs();
    in_valid = 1'b1; is_div = 1'b1; oper1 = 32'd1000; oper2 = 32'd7;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1; in_valid = 1'b1; is_div = 1'b0;
    tick();
    check("flush_div_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_div_ready", {31'b0, in_ready}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("flush_div_no_pulse", pulses, 32'd0);

    // flush with in_valid in IDLE
    set_single(4'd0, 32'd1, 32'd1, 32'd0, 5'b10000, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_idle_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("flush_idle_valid", {31'b0, out_valid}, 32'd0);
    check("flush_idle_wp", {31'b0, wrong_prediction}, 32'd0);
    flush = 1'b0; idle_inputs();
    #1;
    check("flush_idle_ready_after", {31'b0, in_ready}, 32'd1);

    // reset pulse five cycles into a multiply
    set_single(4'd0, 32'd20, 32'd22, 32'd0, 5'b0, 1'b0);
    tick();
    check("pre_rst_res", alu_out, 32'd42);
    idle_inputs();
    in_valid = 1'b1; is_mul = 1'b1; oper1 = 32'd3; oper2 = 32'd9;
    tick();
    in_valid = 1'b0; is_mul = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_res", alu_out, 32'd0);
    check("rst_mid_wp", {31'b0, wrong_prediction}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'b0, in_ready}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("rst_no_pulse", pulses, 32'd0);
    set_single(4'd0, 32'd5, 32'd7, 32'd0, 5'b0, 1'b0);
    tick();
    check("post_rst_valid", {31'b0, out_valid}, 32'd1);
    check("post_rst_res", alu_out, 32'd12);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 Parameter XLEN, default 32: datapath width of pc, operands and result.
REQ-002 Parameter OPW, default 4: width of alu_op.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  an instruction is presented this cycle.
REQ-006 in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 pc, oper1, oper2  input  XLEN each  instruction address and forwarded operands.
REQ-008 alu_op  input  OPW  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu; other codes give add.
REQ-009 is_beq, is_bne, is_blt, is_bge, is_jal, is_mul, is_div, is_rem  input  1 each  one-hot instruction class; all low means plain ALU op.
REQ-010 predicted  input  1  front end predicted taken.
REQ-011 flush  input  1  synchronous kill of anything in the stage.
REQ-012 out_valid  output  1  registered one-cycle result pulse.
REQ-013 alu_out  output  XLEN  registered result.
REQ-014 wrong_prediction  output  1  registered, qualified by out_valid.

Function
REQ-015 States IDLE, MUL, DIV; in_ready SHALL be 1 only in IDLE with flush low.
REQ-016 Accept = in_valid & in_ready at a rising edge.
REQ-017 Single-cycle class (ALU, branch, jal) SHALL give out_valid=1 and alu_out the cycle after accept: latency 1, full throughput.
REQ-018 Shift amounts SHALL use the low log2(XLEN) bits of oper2; slt signed, sltu unsigned; add/sub wrap modulo 2^XLEN.
REQ-019 jal SHALL give alu_out = pc + 1 (word-addressed), taken = 1.
REQ-020 Taken: beq oper1==oper2; bne !=; blt signed <; bge signed >=; jal 1; all others 0.
REQ-021 wrong_prediction SHALL be registered as taken XOR predicted for branch/jal, 0 for every other class, and 0 whenever out_valid is 0.
REQ-022 Branch ops SHALL give alu_out = oper1 - oper2.
REQ-023 is_mul accept: IDLE->MUL; iterative shift-add, one bit per cycle, counter loaded with XLEN-1.
REQ-024 is_div/is_rem accept: IDLE->DIV; unsigned restoring divide, one bit per cycle, same counter.
REQ-025 Final iteration (counter 0): return to IDLE; out_valid pulses one cycle with the result, exactly XLEN cycles after accept; in_ready high again that same cycle.
REQ-026 mul result: low XLEN bits of oper1*oper2; div: quotient; rem: remainder.
REQ-027 Divisor zero: quotient all ones, remainder = oper1; same XLEN-cycle latency.
REQ-028 Operands SHALL be captured at accept; input changes during MUL/DIV have no effect.
REQ-029 flush SHALL win over a simultaneous in_valid: nothing accepted, state->IDLE, out_valid and wrong_prediction 0 next cycle, in-flight mul/div discarded with no later pulse.
REQ-030 No accept and no completing mul/div: out_valid 0 next cycle; alu_out holds its last value.
REQ-031 Asserting more than one class bit is illegal; behaviour is undefined.

Reset
REQ-032 rst high SHALL immediately force state IDLE, counter 0, out_valid 0, wrong_prediction 0, alu_out 0, internal mul/div registers 0.
REQ-033 rst mid-MUL/DIV SHALL abort the operation; no out_valid follows deassertion; in_ready is 1 in the first cycle after release with flush low.

Verification (XLEN=32)
REQ-034 add 5,7 accepted -> next cycle out_valid=1, alu_out=12, wrong_prediction=0; back-to-back sub 3,5 -> 0xFFFFFFFE following cycle.
REQ-035 beq 9,9 with predicted=0 -> wrong_prediction=1; bge -1,0 with predicted=0 -> 0; jal pc=0x40 with predicted=1 -> alu_out=0x41, wrong_prediction=0.
REQ-036 mul 6,7 -> in_ready 0 for 31 cycles, out_valid exactly 32 cycles after accept with alu_out=42, then single-cycle add accepted that cycle.
REQ-037 div 100,0 -> 0xFFFFFFFF; rem 100,0 -> 100; div 0xFFFFFFFF,2 -> 0x7FFFFFFF; each after 32 cycles.
REQ-038 flush 10 cycles into a div, and flush with in_valid in IDLE -> no out_valid, in_ready 1 the cycle after flush drops.
REQ-039 rst pulse during mul at cycle 5 -> outputs 0 immediately, no result pulse, next accepted add completes normally.
